// File: rtl/mpu_controller.sv
// Matrix-unit command controller: a small circular command FIFO feeding a
// sequencer that issues load/store requests and reports completion or errors.
module mpu_controller #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 3,
  parameter int TIMEOUT    = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_in,
  input  logic [1:0]        cmd_opcode_in,
  input  logic [ADDR_W-1:0] cmd_addr_in,
  output logic              cmd_ready_out,
  input  logic              flush_in,
  output logic              load_req_out,
  output logic              store_req_out,
  output logic [ADDR_W-1:0] reg_addr_out,
  input  logic              load_ack_in,
  input  logic              load_error_in,
  input  logic              store_done_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              error_out,
  output logic [1:0]        err_code_out
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] TMAX    = CW'(TIMEOUT - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ISSUE_LD = 3'd1;
  localparam logic [2:0] WAIT_LD  = 3'd2;
  localparam logic [2:0] ISSUE_ST = 3'd3;
  localparam logic [2:0] WAIT_ST  = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;
  localparam logic [2:0] ERR      = 3'd6;

  typedef struct packed {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  cmd_t              mem [FIFO_DEPTH];
  cmd_t              head;
  logic [PW-1:0]     wptr, rptr;
  logic [PW:0]       count;
  logic [2:0]        state, state_nxt;
  logic [CW-1:0]     wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        code_q;
  logic              push, pop;

  assign cmd_ready_out = count < DEPTH_C;
  assign push = cmd_valid_in && cmd_ready_out && !flush_in;
  assign pop  = (state == IDLE) && (count != '0);
  assign head = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{op: cmd_opcode_in, addr: cmd_addr_in};
  end

  // Flush drops only queued entries; a head popped this same cycle still runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush_in) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (pop) begin
          case (head.op)
            2'b00:   state_nxt = DONE;
            2'b01:   state_nxt = ISSUE_LD;
            2'b10:   state_nxt = ISSUE_ST;
            default: state_nxt = ERR;
          endcase
        end
      ISSUE_LD: state_nxt = WAIT_LD;
      ISSUE_ST: state_nxt = WAIT_ST;
      WAIT_LD:
        if (load_error_in)          state_nxt = ERR;
        else if (load_ack_in)       state_nxt = DONE;
        else if (wait_cnt == TMAX)  state_nxt = ERR;
      WAIT_ST:
        if (store_done_in)          state_nxt = DONE;
        else if (wait_cnt == TMAX)  state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  // code_q is only consumed in ERR, so it may be written speculatively while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      code_q   <= 2'b00;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE:
          if (pop) begin
            addr_q <= head.addr;
            code_q <= 2'b11;
          end
        ISSUE_LD, ISSUE_ST: wait_cnt <= '0;
        WAIT_LD: begin
          code_q <= load_error_in ? 2'b01 : 2'b10;
          if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
        end
        WAIT_ST: begin
          code_q <= 2'b10;
          if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign load_req_out  = (state == ISSUE_LD);
  assign store_req_out = (state == ISSUE_ST);
  assign reg_addr_out  = addr_q;
  assign busy_out      = (state != IDLE);
  assign done_out      = (state == DONE);
  assign error_out     = (state == ERR);
  assign err_code_out  = (state == ERR) ? code_q : 2'b00;
endmodule

// File: tb/tb_mpu_controller.sv
// Self-checking bench for mpu_controller: vector table plus hand sequences,
// with an in-order event scoreboard fed from the stimulus side.
module tb_mpu_controller;
  localparam int DEPTH = 4;
  localparam int AW    = 3;
  localparam int TO    = 256;
  localparam int EV_LD = 1, EV_ST = 2, EV_DONE = 3, EV_ERR = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid_in = 1'b0;
  logic [1:0]    cmd_opcode_in = 2'b00;
  logic [AW-1:0] cmd_addr_in = '0;
  logic          cmd_ready_out;
  logic          flush_in = 1'b0;
  logic          load_req_out, store_req_out;
  logic [AW-1:0] reg_addr_out;
  logic          load_ack_in, load_error_in, store_done_in;
  logic          busy_out, done_out, error_out;
  logic [1:0]    err_code_out;

  always #5 clk = ~clk;

  mpu_controller #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_in(cmd_valid_in), .cmd_opcode_in(cmd_opcode_in),
    .cmd_addr_in(cmd_addr_in), .cmd_ready_out(cmd_ready_out),
    .flush_in(flush_in),
    .load_req_out(load_req_out), .store_req_out(store_req_out),
    .reg_addr_out(reg_addr_out),
    .load_ack_in(load_ack_in), .load_error_in(load_error_in),
    .store_done_in(store_done_in),
    .busy_out(busy_out), .done_out(done_out), .error_out(error_out),
    .err_code_out(err_code_out)
  );

  typedef struct { int kind; int val; } ev_t;
  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    int            rmode;  // 0 none, 1 ack/done, 2 load_error, 3 ack+error
    int            dly;
    int            lat;    // negedges from request to the end pulse
    int            ek;
    int            code;
  } vec_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  rmode = 0;
  int  rdelay = 1;
  bit  r_ld;
  int  r_m;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(int kind, int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic check_reset(string tag);
    check({tag, "_ready"},    int'(cmd_ready_out), 1);
    check({tag, "_busy"},     int'(busy_out), 0);
    check({tag, "_addr"},     int'(reg_addr_out), 0);
    check({tag, "_reqs"},     int'({load_req_out, store_req_out}), 0);
    check({tag, "_done_err"}, int'({done_out, error_out}), 0);
    check({tag, "_code"},     int'(err_code_out), 0);
  endtask

  task automatic send(logic [1:0] op, logic [AW-1:0] addr);
    @(posedge clk); #1;
    cmd_valid_in = 1'b1; cmd_opcode_in = op; cmd_addr_in = addr;
    @(posedge clk); #1;
    cmd_valid_in = 1'b0;
  endtask

  task automatic wait_req(string tag);
    bit got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = load_req_out || store_req_out;
    end
    check({tag, "_req_seen"}, int'(got), 1);
  endtask

  task automatic drain(string tag, int bound);
    for (int k = 0; k < bound && exp_q.size() != 0; k++) @(negedge clk);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // Scoreboard: every visible DUT event must match the head of exp_q.
  always @(negedge clk) begin : monitor
    ev_t a, e;
    if (!rst && (load_req_out || store_req_out || done_out || error_out)) begin
      a.kind = load_req_out ? EV_LD : store_req_out ? EV_ST : done_out ? EV_DONE : EV_ERR;
      a.val  = (load_req_out || store_req_out) ? int'(reg_addr_out) :
               error_out ? int'(err_code_out) : 0;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected: got kind %0d val %0d, expected no event", a.kind, a.val);
      end else begin
        e = exp_q.pop_front();
        check("sb_kind", a.kind, e.kind);
        check("sb_val", a.val, e.val);
      end
    end
  end

  // Response agent: reacts to each request according to rmode/rdelay.
  initial begin
    load_ack_in = 1'b0; load_error_in = 1'b0; store_done_in = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && (load_req_out || store_req_out) && rmode != 0) begin
        r_ld = load_req_out;
        r_m  = rmode;
        repeat (rdelay) @(posedge clk);
        #1;
        if (r_ld) begin
          load_ack_in   = (r_m == 1 || r_m == 3);
          load_error_in = (r_m == 2 || r_m == 3);
        end else begin
          store_done_in = (r_m == 1);
          load_error_in = (r_m == 2);
          load_ack_in   = (r_m == 3);
        end
        @(posedge clk); #1;
        load_ack_in = 1'b0; load_error_in = 1'b0; store_done_in = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    int   lat, waited;
    bit   has_req;
    tbl[0] = '{2'd1, 3'd5, 1, 3, 4,      EV_DONE, 0};
    tbl[1] = '{2'd2, 3'd3, 1, 1, 2,      EV_DONE, 0};
    tbl[2] = '{2'd1, 3'd1, 3, 2, 3,      EV_ERR,  1};
    tbl[3] = '{2'd1, 3'd7, 2, 1, 2,      EV_ERR,  1};
    tbl[4] = '{2'd0, 3'd0, 0, 1, 0,      EV_DONE, 0};
    tbl[5] = '{2'd3, 3'd4, 0, 1, 0,      EV_ERR,  3};
    tbl[6] = '{2'd2, 3'd6, 0, 1, TO + 1, EV_ERR,  2};
    tbl[7] = '{2'd1, 3'd2, 0, 1, TO + 1, EV_ERR,  2};
    tbl[8] = '{2'd2, 3'd0, 1, 4, 5,      EV_DONE, 0};
    tbl[9] = '{2'd2, 3'd1, 2, 1, TO + 1, EV_ERR,  2};

    #2 rst = 1'b1;
    #1 check_reset("por");
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    foreach (tbl[i]) begin
      rmode   = tbl[i].rmode;
      rdelay  = tbl[i].dly;
      has_req = (tbl[i].op == 2'd1) || (tbl[i].op == 2'd2);
      if (tbl[i].op == 2'd1) expect_ev(EV_LD, int'(tbl[i].addr));
      if (tbl[i].op == 2'd2) expect_ev(EV_ST, int'(tbl[i].addr));
      expect_ev(tbl[i].ek, tbl[i].code);
      send(tbl[i].op, tbl[i].addr);
      if (has_req) begin
        wait_req("vec");
        lat = 0;
        for (int k = 1; k <= TO + 20 && lat == 0; k++) begin
          @(negedge clk);
          if (done_out || error_out) lat = k;
        end
        check("vec_latency", lat, tbl[i].lat);
        check("vec_addr_hold", int'(reg_addr_out), int'(tbl[i].addr));
      end else begin
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
          @(negedge clk);
          if (done_out || error_out) lat = k;
        end
        check("vec_end_seen", int'(lat != 0), 1);
      end
      @(negedge clk);
      check("vec_idle_after", int'({busy_out, done_out, error_out}), 0);
    end

    // NOP, illegal, LOAD queued together complete strictly in order.
    rmode = 1; rdelay = 2;
    expect_ev(EV_DONE, 0); expect_ev(EV_ERR, 3);
    expect_ev(EV_LD, 2);   expect_ev(EV_DONE, 0);
    @(posedge clk); #1;
    cmd_valid_in = 1'b1; cmd_opcode_in = 2'd0; cmd_addr_in = 3'd0;
    @(posedge clk); #1 cmd_opcode_in = 2'd3; cmd_addr_in = 3'd1;
    @(posedge clk); #1 cmd_opcode_in = 2'd1; cmd_addr_in = 3'd2;
    @(posedge clk); #1 cmd_valid_in = 1'b0;
    drain("order", 60);

    // Stalled STORE holds the FIFO; 4 loads fill it and the 5th waits for a slot.
    rmode = 0;
    expect_ev(EV_ST, 5); expect_ev(EV_ERR, 2);
    for (int i = 0; i < 5; i++) begin expect_ev(EV_LD, i); expect_ev(EV_DONE, 0); end
    send(2'd2, 3'd5);
    wait_req("full");
    @(posedge clk); #1;
    rmode = 1; rdelay = 1;
    for (int i = 0; i < 4; i++) begin
      cmd_valid_in = 1'b1; cmd_opcode_in = 2'd1; cmd_addr_in = AW'(i);
      @(negedge clk);
      check("full_ready_fill", int'(cmd_ready_out), 1);
      @(posedge clk); #1;
    end
    cmd_addr_in = 3'd4;
    @(negedge clk);
    check("full_ready_low", int'(cmd_ready_out), 0);
    waited = 0;
    while (!cmd_ready_out && waited < TO + 20) begin
      @(negedge clk);
      waited++;
    end
    check("full_blocked_long", int'(waited >= 200), 1);
    check("full_ready_back", int'(cmd_ready_out), 1);
    @(posedge clk); #1 cmd_valid_in = 1'b0;
    drain("full", 100);

    // Flush with three queued entries; the push in the flush cycle is dropped.
    rmode = 0;
    expect_ev(EV_LD, 6); expect_ev(EV_ERR, 2);
    send(2'd1, 3'd6);
    wait_req("flush");
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      cmd_valid_in = 1'b1; cmd_opcode_in = 2'd2; cmd_addr_in = AW'(i);
    end
    @(posedge clk); #1;
    cmd_addr_in = 3'd7; flush_in = 1'b1;
    @(posedge clk); #1;
    cmd_valid_in = 1'b0; flush_in = 1'b0;
    @(negedge clk);
    check("flush_busy_kept", int'(busy_out), 1);
    drain("flush", TO + 20);
    repeat (20) @(negedge clk);
    check("flush_idle", int'(busy_out), 0);

    // Reset in WAIT_LD with a loaded queue abandons everything silently.
    rmode = 0;
    expect_ev(EV_LD, 3);
    send(2'd1, 3'd3);
    wait_req("rst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cmd_valid_in = 1'b1; cmd_opcode_in = 2'd1; cmd_addr_in = AW'(i + 4);
    end
    @(posedge clk); #1 cmd_valid_in = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset("midrst");
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) @(negedge clk);
    check("midrst_idle", int'(busy_out), 0);
    check("midrst_ready", int'(cmd_ready_out), 1);

    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mpu_controller.md
MPU_CONTROLLER -- requirements
Module: mpu_controller

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: command FIFO entries; power of two, at least 2.
REQ-002 Parameter ADDR_W, default 3: matrix register address width.
REQ-003 Parameter TIMEOUT, default 256: maximum wait cycles for a load or store response.
REQ-004 clk  in  1  system clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset; one clock, asynchronous and active-high.
REQ-006 cmd_valid_in  in  1  command offered.
REQ-007 cmd_opcode_in  in  2  00 NOP, 01 LOAD, 10 STORE, 11 illegal.
REQ-008 cmd_addr_in  in  ADDR_W  target matrix register.
REQ-009 cmd_ready_out  out  1  FIFO not full; a command is accepted when cmd_valid_in and cmd_ready_out are both high.
REQ-010 flush_in  in  1  discard all queued, not-yet-popped commands.
REQ-011 load_req_out  out  1  one-cycle request to the load unit.
REQ-012 store_req_out  out  1  one-cycle request to the store unit.
REQ-013 reg_addr_out  out  ADDR_W  address of the active command; held stable from ISSUE until completion.
REQ-014 load_ack_in  in  1  load unit completion.
REQ-015 load_error_in  in  1  load unit error.
REQ-016 store_done_in  in  1  store unit completion.
REQ-017 busy_out  out  1  high whenever state is not IDLE.
REQ-018 done_out  out  1  one-cycle completion pulse.
REQ-019 error_out  out  1  one-cycle error pulse.
REQ-020 err_code_out  out  2  error code, valid with error_out: 01 device, 10 timeout, 11 illegal opcode.

Function
REQ-021 FIFO: circular, with read and write pointers of log2(FIFO_DEPTH) bits that wrap, plus a count of log2(FIFO_DEPTH)+1 bits.
REQ-022 cmd_ready_out is combinational: high when count < FIFO_DEPTH.
REQ-023 A push while full is ignored; no state changes.
REQ-024 A push and a pop in the same cycle both occur; count is unchanged.
REQ-025 flush_in clears the pointers and count on the next edge and overrides a push in the same cycle; the active command continues.
REQ-026 States are IDLE, ISSUE_LD, WAIT_LD, ISSUE_ST, WAIT_ST, DONE, ERR.
REQ-027 IDLE: when count > 0, pop the head and latch opcode and address; go to ISSUE_LD for LOAD, ISSUE_ST for STORE, DONE for NOP, ERR (code 11) for illegal.
REQ-028 ISSUE_LD / ISSUE_ST: assert load_req_out / store_req_out for exactly one cycle, clear the wait counter, then go to WAIT_LD / WAIT_ST.
REQ-029 WAIT_LD: load_error_in goes to ERR (01); else load_ack_in goes to DONE; else counter reaching TIMEOUT-1 goes to ERR (10); else increment the counter.
REQ-030 If load_ack_in and load_error_in are high together, the error wins.
REQ-031 WAIT_ST: store_done_in goes to DONE; else the timeout goes to ERR (10); else increment the counter.
REQ-032 Responses are ignored outside their own WAIT state.
REQ-033 DONE: done_out = 1 for one cycle, then go to IDLE.
REQ-034 ERR: error_out = 1 for one cycle with err_code_out valid, then go to IDLE; err_code_out is 00 otherwise.
REQ-035 Latency: a command accepted at edge N into an empty FIFO with state IDLE is popped at edge N+1; its request is high during the cycle after edge N+1.
REQ-036 Back-to-back commands are processed in order; the controller returns to IDLE for one cycle between commands.
REQ-037 The wait counter is ceil(log2(TIMEOUT))+1 bits and saturates rather than wrapping.

Reset
REQ-038 rst high immediately forces state IDLE, FIFO empty, counter 0, all req/done/error outputs 0, err_code_out 00, reg_addr_out 0, busy_out 0, cmd_ready_out 1.
REQ-039 Reset mid-operation abandons the active command without emitting done_out or error_out; the bench must discard any late acks.

Verification
REQ-040 LOAD addr 5, ack 3 cycles after load_req_out -> load_req_out one cycle with reg_addr_out=5; done_out 1 cycle after ack; busy_out back to 0.
REQ-041 Push 5 commands back-to-back with DEPTH=4 and responses stalled -> cmd_ready_out low after 4 accepted; 5th ignored; pushes resume once the first pop frees a slot.
REQ-042 STORE with no store_done_in -> error_out with err_code_out=10 exactly TIMEOUT cycles after entering WAIT_ST.
REQ-043 LOAD with load_ack_in and load_error_in high in the same cycle -> error_out, err_code_out=01, no done_out.
REQ-044 Queue NOP, opcode 11, LOAD 2 -> done_out, then error_out with code 11, then load_req_out with addr 2, in order.
REQ-045 Assert rst during WAIT_LD and flush_in with 3 queued commands -> all outputs at reset values; no further requests.
